mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one single-port memory between the core's instruction bus and data bus.
//  Arbitrates concurrent requests and holds the granted request on the memory port until ack.
//  Routes read data and ack back to the owner. Drives the ibus/dbus busy flags that the core FSM waits on.
//  Sits between the core bus ports and the unified memory/bridge.
// PARAMETERS
//  p_addr_w     32   address width
//  p_data_w     32   data width (multiple of 8)
//  p_fixed_prio 1    1: dbus wins every conflict; 0: round-robin on conflict
//  p_timeout    255  max cycles in a grant state before abort; 0 disables the timeout
// PORTS
//  i_clk        in   1            clock
//  i_rst        in   1            reset, synchronous, active-high
//  i_ibus_req   in   1            instruction fetch request
//  i_ibus_addr  in   p_addr_w     fetch address
//  o_ibus_rdata out  p_data_w     fetch data, valid with o_ibus_ack
//  o_ibus_ack   out  1            fetch done, 1-cycle pulse
//  o_ibus_busy  out  1            arbiter cannot take a fetch now
//  i_dbus_req   in   1            data request
//  i_dbus_we    in   1            1 = write, 0 = read
//  i_dbus_be    in   p_data_w/8   byte enables
//  i_dbus_addr  in   p_addr_w     data address
//  i_dbus_wdata in   p_data_w     write data
//  o_dbus_rdata out  p_data_w     read data, valid with o_dbus_ack
//  o_dbus_ack   out  1            data access done, 1-cycle pulse
//  o_dbus_busy  out  1            arbiter cannot take a data access now
//  o_mem_req    out  1            memory request, held until ack
//  o_mem_we     out  1            memory write enable
//  o_mem_be     out  p_data_w/8   memory byte enables (all ones for fetch)
//  o_mem_addr   out  p_addr_w     memory address
//  o_mem_wdata  out  p_data_w     memory write data
//  i_mem_rdata  in   p_data_w     memory read data
//  i_mem_ack    in   1            memory access complete
//  o_timeout    out  1            1-cycle pulse: grant aborted by the timeout
// BEHAVIOUR
//  - States: st_idle, st_ibus, st_dbus.
//  - Reset: state st_idle; all o_mem_* = 0; owner ack/rdata = 0; busy = 0; timeout counter = 0;
//    round-robin pointer favours ibus.
//  - st_idle, request sampling:
//    - Exactly one req: grant it.
//    - Both reqs, p_fixed_prio=1: grant dbus.
//    - Both reqs, p_fixed_prio=0: grant the side not served last, then flip the pointer.
//  - Grant: on the next clock edge, o_mem_* registers the request fields and the state moves to st_ibus/st_dbus.
//    Request-to-o_mem_req latency is 1 cycle.
//  - Grant state:
//    - o_mem_* are held stable and o_mem_req stays 1 until i_mem_ack.
//    - Requester req/addr/data changes after the grant are ignored; req deassertion does not cancel the access.
//  - Completion:
//    - The cycle i_mem_ack=1 in a grant state, owner ack=1 and owner rdata=i_mem_rdata, combinational, same cycle.
//    - Next state is st_idle, with o_mem_req=0.
//    - Minimum 1 idle cycle between transactions.
//  - Non-owner ack is always 0. Non-owner rdata is 0.
//  - i_mem_ack in st_idle is ignored.
//  - Busy:
//    - o_ibus_busy = o_dbus_busy = (state != st_idle).
//    - Busy is additionally 1 in st_idle for the side losing a same-cycle conflict.
//  - Timeout (p_timeout>0):
//    - The counter clears on entry to a grant state and increments each grant cycle without ack.
//    - If counter == p_timeout-1 and no ack: owner ack=1, owner rdata=0, o_timeout=1 that cycle; next state st_idle.
//    - Ack and timeout in the same cycle: the ack wins and o_timeout=0.
//  - Counter width is $clog2(p_timeout+1); the counter saturates and never wraps.
//  - Reset mid-transaction: the next cycle is st_idle with o_mem_req=0. No ack is produced for the aborted access.
// STRUCTURE
//  - pck_bus holds typedefs arb_state_e {st_idle, st_ibus, st_dbus} and bus_owner_e {own_ibus, own_dbus}.
//  - Single module; no sub-module. Timeout counter and round-robin pointer are inline.
// TESTING
//  - Fetch only: ibus_req, addr 0x100, mem acks after 3 cycles with 0xDEADBEEF ->
//    o_mem_req rises 1 cycle after the request, o_ibus_ack pulses with 0xDEADBEEF, busy=1 for 4 cycles.
//  - Conflict, p_fixed_prio=1: ibus and dbus req in the same cycle, 3 times ->
//    dbus granted each time, ibus served only after dbus acks.
//  - Conflict, p_fixed_prio=0: both req held continuously -> grants alternate ibus, dbus, ibus, dbus.
//  - Write: dbus we=1, be=4'b0011, wdata 0x1234, addr 0x2000 -> o_mem_* carry exactly these values until ack.
//  - Timeout, p_timeout=4, mem never acks -> o_dbus_ack=1, rdata=0, o_timeout=1 in the 4th grant cycle; then idle.
//  - Reset asserted while in st_ibus -> o_mem_req=0 the next cycle, no o_ibus_ack; a fresh request after reset is served normally.

Source files
------------

// File: rtl/pck_bus.sv
// Shared types for the core bus arbiter.
package pck_bus;

   typedef enum logic [1:0] {st_idle, st_ibus, st_dbus} arb_state_e;
   typedef enum logic {own_ibus, own_dbus} bus_owner_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory between the instruction and data buses,
// holding the granted request on the memory port until ack or timeout.
module mem_bus_arbiter
   import pck_bus::*;
#(
   parameter int unsigned p_addr_w     = 32,
   parameter int unsigned p_data_w     = 32,
   parameter int unsigned p_fixed_prio = 1,
   parameter int unsigned p_timeout    = 255
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_ibus_req,
   input  logic [p_addr_w-1:0]   i_ibus_addr,
   output logic [p_data_w-1:0]   o_ibus_rdata,
   output logic                  o_ibus_ack,
   output logic                  o_ibus_busy,
   input  logic                  i_dbus_req,
   input  logic                  i_dbus_we,
   input  logic [p_data_w/8-1:0] i_dbus_be,
   input  logic [p_addr_w-1:0]   i_dbus_addr,
   input  logic [p_data_w-1:0]   i_dbus_wdata,
   output logic [p_data_w-1:0]   o_dbus_rdata,
   output logic                  o_dbus_ack,
   output logic                  o_dbus_busy,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic [p_data_w/8-1:0] o_mem_be,
   output logic [p_addr_w-1:0]   o_mem_addr,
   output logic [p_data_w-1:0]   o_mem_wdata,
   input  logic [p_data_w-1:0]   i_mem_rdata,
   input  logic                  i_mem_ack,
   output logic                  o_timeout
);

   localparam int unsigned c_cnt_w = (p_timeout > 0) ? $clog2(p_timeout + 1) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((p_timeout > 0) ? p_timeout - 1 : 0);

   arb_state_e         state;
   bus_owner_e         rr_last;
   logic [c_cnt_w-1:0] tmo_cnt;
   logic               conflict;
   logic               grant_dbus;
   logic               in_grant;
   logic               tmo_hit;
   logic               done;

   // rr_last records the side served last; the other side wins the next conflict
   assign conflict   = i_ibus_req & i_dbus_req;
   assign grant_dbus = i_dbus_req & (~i_ibus_req | (p_fixed_prio != 0) | (rr_last == own_ibus));
   assign in_grant   = (state != st_idle);
   assign tmo_hit    = (p_timeout != 0) && in_grant && !i_mem_ack && (tmo_cnt == c_cnt_last);
   assign done       = in_grant & (i_mem_ack | tmo_hit) & ~i_rst;

   assign o_ibus_ack   = done & (state == st_ibus);
   assign o_dbus_ack   = done & (state == st_dbus);
   assign o_ibus_rdata = (state == st_ibus && i_mem_ack && !i_rst) ? i_mem_rdata : '0;
   assign o_dbus_rdata = (state == st_dbus && i_mem_ack && !i_rst) ? i_mem_rdata : '0;
   assign o_timeout    = tmo_hit & ~i_rst;
   assign o_ibus_busy  = in_grant | (conflict & grant_dbus);
   assign o_dbus_busy  = in_grant | (conflict & ~grant_dbus);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= st_idle;
         rr_last     <= own_dbus;
         tmo_cnt     <= '0;
         o_mem_req   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_be    <= '0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
      end else begin
         case (state)
            st_idle: begin
               tmo_cnt <= '0;
               if (i_ibus_req || i_dbus_req) begin
                  o_mem_req <= 1'b1;
                  if (grant_dbus) begin
                     state       <= st_dbus;
                     rr_last     <= own_dbus;
                     o_mem_we    <= i_dbus_we;
                     o_mem_be    <= i_dbus_be;
                     o_mem_addr  <= i_dbus_addr;
                     o_mem_wdata <= i_dbus_wdata;
                  end else begin
                     state       <= st_ibus;
                     rr_last     <= own_ibus;
                     o_mem_we    <= 1'b0;
                     o_mem_be    <= '1;
                     o_mem_addr  <= i_ibus_addr;
                     o_mem_wdata <= '0;
                  end
               end
            end
            default: begin
               if (i_mem_ack || tmo_hit) begin
                  state       <= st_idle;
                  tmo_cnt     <= '0;
                  o_mem_req   <= 1'b0;
                  o_mem_we    <= 1'b0;
                  o_mem_be    <= '0;
                  o_mem_addr  <= '0;
                  o_mem_wdata <= '0;
               end else if (tmo_cnt != c_cnt_max) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// transaction-level model of the arbitration and timeout rules.
module tb_mem_bus_arbiter;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        iack;
      logic [31:0] irdata;
      logic        ibusy;
      logic        dack;
      logic [31:0] drdata;
      logic        dbusy;
      logic        tmo;
   } obs_t;

   logic clk, rst;

   // dut_a: fixed priority, timeout 4
   logic        ibus_req, ibus_ack, ibus_busy, dbus_req, dbus_we, dbus_ack, dbus_busy;
   logic [31:0] ibus_addr, ibus_rdata, dbus_addr, dbus_wdata, dbus_rdata;
   logic [3:0]  dbus_be, mem_be;
   logic        mem_req, mem_we, mem_ack, tmo;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   // dut_b: round-robin, timeout disabled
   logic        ibus_req_b, ibus_ack_b, ibus_busy_b, dbus_req_b, dbus_we_b, dbus_ack_b, dbus_busy_b;
   logic [31:0] ibus_addr_b, ibus_rdata_b, dbus_addr_b, dbus_wdata_b, dbus_rdata_b;
   logic [3:0]  dbus_be_b, mem_be_b;
   logic        mem_req_b, mem_we_b, mem_ack_b, tmo_b;
   logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

   int checks = 0;
   int passes = 0;

   mem_bus_arbiter #(
      .p_addr_w(32), .p_data_w(32), .p_fixed_prio(1), .p_timeout(4)
   ) dut_a (
      .i_clk(clk), .i_rst(rst),
      .i_ibus_req(ibus_req), .i_ibus_addr(ibus_addr), .o_ibus_rdata(ibus_rdata),
      .o_ibus_ack(ibus_ack), .o_ibus_busy(ibus_busy),
      .i_dbus_req(dbus_req), .i_dbus_we(dbus_we), .i_dbus_be(dbus_be),
      .i_dbus_addr(dbus_addr), .i_dbus_wdata(dbus_wdata), .o_dbus_rdata(dbus_rdata),
      .o_dbus_ack(dbus_ack), .o_dbus_busy(dbus_busy),
      .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_be(mem_be), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
      .o_timeout(tmo)
   );

   mem_bus_arbiter #(
      .p_addr_w(32), .p_data_w(32), .p_fixed_prio(0), .p_timeout(0)
   ) dut_b (
      .i_clk(clk), .i_rst(rst),
      .i_ibus_req(ibus_req_b), .i_ibus_addr(ibus_addr_b), .o_ibus_rdata(ibus_rdata_b),
      .o_ibus_ack(ibus_ack_b), .o_ibus_busy(ibus_busy_b),
      .i_dbus_req(dbus_req_b), .i_dbus_we(dbus_we_b), .i_dbus_be(dbus_be_b),
      .i_dbus_addr(dbus_addr_b), .i_dbus_wdata(dbus_wdata_b), .o_dbus_rdata(dbus_rdata_b),
      .o_dbus_ack(dbus_ack_b), .o_dbus_busy(dbus_busy_b),
      .o_mem_req(mem_req_b), .o_mem_we(mem_we_b), .o_mem_be(mem_be_b), .o_mem_addr(mem_addr_b),
      .o_mem_wdata(mem_wdata_b), .i_mem_rdata(mem_rdata_b), .i_mem_ack(mem_ack_b),
      .o_timeout(tmo_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t obs_a();
      return '{mem_req, mem_we, mem_be, mem_addr, mem_wdata, ibus_ack, ibus_rdata, ibus_busy,
               dbus_ack, dbus_rdata, dbus_busy, tmo};
   endfunction

   function automatic obs_t obs_b();
      return '{mem_req_b, mem_we_b, mem_be_b, mem_addr_b, mem_wdata_b, ibus_ack_b, ibus_rdata_b,
               ibus_busy_b, dbus_ack_b, dbus_rdata_b, dbus_busy_b, tmo_b};
   endfunction

   task automatic idle_inputs();
      ibus_req = 0; ibus_addr = 0; dbus_req = 0; dbus_we = 0; dbus_be = 0;
      dbus_addr = 0; dbus_wdata = 0; mem_rdata = 0; mem_ack = 0;
      ibus_req_b = 0; ibus_addr_b = 0; dbus_req_b = 0; dbus_we_b = 0; dbus_be_b = 0;
      dbus_addr_b = 0; dbus_wdata_b = 0; mem_rdata_b = 0; mem_ack_b = 0;
   endtask

   task automatic test_reset();
      obs_t exp;
      rst = 1;
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      exp = '0;
      checks++;
      if (obs_a() !== exp) $display("FAIL reset_a got=%h exp=%h", obs_a(), exp);
      else passes++;
      checks++;
      if (obs_b() !== exp) $display("FAIL reset_b got=%h exp=%h", obs_b(), exp);
      else passes++;
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_fetch();
      obs_t exp;
      int   busy_cnt = 0;
      @(negedge clk);
      ibus_req = 1; ibus_addr = 32'h100;
      #1;
      exp = '0;
      checks++;
      if (obs_a() !== exp) $display("FAIL fetch_req got=%h exp=%h", obs_a(), exp);
      else passes++;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         ibus_req  = 0;
         ibus_addr = $urandom;
         mem_ack   = (c == 4);
         mem_rdata = (c == 4) ? 32'hDEADBEEF : $urandom;
         #1;
         exp = '0;
         if (c <= 4) begin
            exp.req = 1; exp.be = 4'hf; exp.addr = 32'h100; exp.ibusy = 1; exp.dbusy = 1;
         end
         if (c == 4) begin
            exp.iack = 1; exp.irdata = 32'hDEADBEEF;
         end
         if (ibus_busy) busy_cnt++;
         checks++;
         if (obs_a() !== exp) $display("FAIL fetch_c%0d got=%h exp=%h", c, obs_a(), exp);
         else passes++;
      end
      mem_ack = 0;
      checks++;
      if (busy_cnt !== 4) $display("FAIL fetch_busy_cycles got=%0d exp=4", busy_cnt);
      else passes++;
   endtask

   task automatic test_conflict_fixed();
      obs_t        exp;
      logic [31:0] ia, da, dw, r;
      for (int k = 0; k < 3; k++) begin
         ia = $urandom; da = $urandom; dw = $urandom;
         @(negedge clk);
         ibus_req = 1; ibus_addr = ia;
         dbus_req = 1; dbus_addr = da; dbus_we = 0; dbus_be = 4'hf; dbus_wdata = dw;
         #1;
         exp = '0; exp.ibusy = 1;
         checks++;
         if (obs_a() !== exp) $display("FAIL conf%0d_idle got=%h exp=%h", k, obs_a(), exp);
         else passes++;
         r = $urandom;
         @(negedge clk);
         dbus_req = 0; ibus_addr = $urandom; mem_ack = 1; mem_rdata = r;
         #1;
         exp = '0;
         exp.req = 1; exp.be = 4'hf; exp.addr = da; exp.wdata = dw;
         exp.dack = 1; exp.drdata = r; exp.ibusy = 1; exp.dbusy = 1;
         checks++;
         if (obs_a() !== exp) $display("FAIL conf%0d_dbus got=%h exp=%h", k, obs_a(), exp);
         else passes++;
         @(negedge clk);
         mem_ack = 0; ibus_addr = ia;
         #1;
         exp = '0;
         checks++;
         if (obs_a() !== exp) $display("FAIL conf%0d_gap got=%h exp=%h", k, obs_a(), exp);
         else passes++;
         r = $urandom;
         @(negedge clk);
         ibus_req = 0; mem_ack = 1; mem_rdata = r;
         #1;
         exp = '0;
         exp.req = 1; exp.be = 4'hf; exp.addr = ia;
         exp.iack = 1; exp.irdata = r; exp.ibusy = 1; exp.dbusy = 1;
         checks++;
         if (obs_a() !== exp) $display("FAIL conf%0d_ibus got=%h exp=%h", k, obs_a(), exp);
         else passes++;
         @(negedge clk);
         mem_ack = 0;
         #1;
         exp = '0;
         checks++;
         if (obs_a() !== exp) $display("FAIL conf%0d_end got=%h exp=%h", k, obs_a(), exp);
         else passes++;
      end
   endtask

   task automatic test_write();
      obs_t        exp;
      logic [31:0] r;
      @(negedge clk);
      dbus_req = 1; dbus_we = 1; dbus_be = 4'b0011; dbus_wdata = 32'h1234; dbus_addr = 32'h2000;
      #1;
      for (int c = 1; c <= 3; c++) begin
         r = $urandom;
         @(negedge clk);
         dbus_req = 1'($urandom); dbus_we = 1'($urandom); dbus_be = 4'($urandom);
         dbus_addr = $urandom; dbus_wdata = $urandom;
         mem_ack = (c == 3); mem_rdata = r;
         #1;
         exp = '0;
         exp.req = 1; exp.we = 1; exp.be = 4'b0011; exp.addr = 32'h2000; exp.wdata = 32'h1234;
         exp.ibusy = 1; exp.dbusy = 1;
         if (c == 3) begin
            exp.dack = 1; exp.drdata = r;
         end
         checks++;
         if (obs_a() !== exp) $display("FAIL write_c%0d got=%h exp=%h", c, obs_a(), exp);
         else passes++;
      end
      @(negedge clk);
      dbus_req = 0; dbus_we = 0; mem_ack = 0;
      #1;
      exp = '0;
      checks++;
      if (obs_a() !== exp) $display("FAIL write_end got=%h exp=%h", obs_a(), exp);
      else passes++;
   endtask

   task automatic test_timeout();
      obs_t exp;
      @(negedge clk);
      dbus_req = 1; dbus_we = 0; dbus_be = 4'hf; dbus_addr = 32'h3000; dbus_wdata = 0;
      #1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         dbus_req = 0; mem_ack = 0; mem_rdata = 32'hA5A5A5A5;
         #1;
         exp = '0;
         if (c <= 4) begin
            exp.req = 1; exp.be = 4'hf; exp.addr = 32'h3000; exp.ibusy = 1; exp.dbusy = 1;
         end
         if (c == 4) begin
            exp.dack = 1; exp.tmo = 1;
         end
         checks++;
         if (obs_a() !== exp) $display("FAIL timeout_c%0d got=%h exp=%h", c, obs_a(), exp);
         else passes++;
      end
   endtask

   task automatic test_reset_mid();
      obs_t        exp;
      logic [31:0] r;
      @(negedge clk);
      ibus_req = 1; ibus_addr = 32'h400;
      #1;
      @(negedge clk);
      ibus_req = 0;
      #1;
      checks++;
      if (mem_req !== 1'b1) $display("FAIL rstmid_granted got=%b exp=1", mem_req);
      else passes++;
      @(negedge clk);
      rst = 1;
      #1;
      checks++;
      if (ibus_ack !== 1'b0) $display("FAIL rstmid_noack got=%b exp=0", ibus_ack);
      else passes++;
      r = $urandom;
      @(negedge clk);
      rst = 0; mem_ack = 1; mem_rdata = r;
      #1;
      exp = '0;
      checks++;
      if (obs_a() !== exp) $display("FAIL rstmid_idle got=%h exp=%h", obs_a(), exp);
      else passes++;
      @(negedge clk);
      mem_ack = 0; ibus_req = 1; ibus_addr = 32'h500;
      #1;
      r = $urandom;
      @(negedge clk);
      ibus_req = 0; mem_ack = 1; mem_rdata = r;
      #1;
      exp = '0;
      exp.req = 1; exp.be = 4'hf; exp.addr = 32'h500; exp.iack = 1; exp.irdata = r;
      exp.ibusy = 1; exp.dbusy = 1;
      checks++;
      if (obs_a() !== exp) $display("FAIL rstmid_fresh got=%h exp=%h", obs_a(), exp);
      else passes++;
      @(negedge clk);
      mem_ack = 0;
      #1;
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_addr, r;
      int          n;
      logic        held_ok;
      @(negedge clk);
      ibus_req_b = 1; ibus_addr_b = 32'h10;
      dbus_req_b = 1; dbus_addr_b = 32'h20; dbus_we_b = 0; dbus_be_b = 4'hf;
      #1;
      checks++;
      if ({ibus_busy_b, dbus_busy_b} !== 2'b01)
         $display("FAIL rr_idle_busy got=%b exp=01", {ibus_busy_b, dbus_busy_b});
      else passes++;
      for (int k = 0; k < 4; k++) begin
         exp_addr = (k % 2 == 0) ? 32'h10 : 32'h20;
         n = 0;
         do begin
            @(negedge clk);
            mem_ack_b = 0;
            #1;
            n++;
         end while (!mem_req_b && n < 5);
         checks++;
         if (mem_req_b !== 1'b1 || mem_addr_b !== exp_addr)
            $display("FAIL rr_grant%0d got req=%b addr=%h exp req=1 addr=%h",
                     k, mem_req_b, mem_addr_b, exp_addr);
         else passes++;
         if (k == 0) begin
            held_ok = 1;
            repeat (10) begin
               @(negedge clk);
               #1;
               if (tmo_b !== 1'b0 || mem_req_b !== 1'b1 || ibus_ack_b !== 1'b0) held_ok = 0;
            end
            checks++;
            if (!held_ok) $display("FAIL rr_no_timeout got=0 exp=1");
            else passes++;
         end
         r = $urandom;
         @(negedge clk);
         mem_ack_b = 1; mem_rdata_b = r;
         #1;
         checks++;
         if (k % 2 == 0) begin
            if ({ibus_ack_b, dbus_ack_b} !== 2'b10 || ibus_rdata_b !== r)
               $display("FAIL rr_ack%0d got=%b/%h exp=10/%h", k, {ibus_ack_b, dbus_ack_b},
                        ibus_rdata_b, r);
            else passes++;
         end else begin
            if ({ibus_ack_b, dbus_ack_b} !== 2'b01 || dbus_rdata_b !== r)
               $display("FAIL rr_ack%0d got=%b/%h exp=01/%h", k, {ibus_ack_b, dbus_ack_b},
                        dbus_rdata_b, r);
            else passes++;
         end
      end
      @(negedge clk);
      mem_ack_b = 0; ibus_req_b = 0; dbus_req_b = 0;
      @(negedge clk);
   endtask

   // Model: owner 0 = none, 1 = ibus, 2 = dbus; grant cycles counted from 0.
   task automatic test_random();
      obs_t        exp, held;
      int          owner = 0;
      int          gcnt = 0;
      logic        fin;
      held = '0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         @(negedge clk);
         ibus_req   = ($urandom % 3) != 0;
         dbus_req   = ($urandom % 3) == 0;
         ibus_addr  = $urandom;
         dbus_addr  = $urandom;
         dbus_wdata = $urandom;
         dbus_we    = 1'($urandom);
         dbus_be    = 4'($urandom);
         mem_rdata  = $urandom;
         mem_ack    = (owner != 0) ? (($urandom % 3) == 0) : (($urandom % 4) == 0);
         #1;
         exp = '0;
         fin = 0;
         if (owner == 0) begin
            exp.ibusy = ibus_req & dbus_req;
         end else begin
            exp = held;
            exp.ibusy = 1; exp.dbusy = 1;
            fin = mem_ack || (gcnt == 3);
            exp.tmo = !mem_ack && (gcnt == 3);
            if (owner == 1) begin
               exp.iack = fin; exp.irdata = mem_ack ? mem_rdata : 32'h0;
            end else begin
               exp.dack = fin; exp.drdata = mem_ack ? mem_rdata : 32'h0;
            end
         end
         checks++;
         if (obs_a() !== exp) $display("FAIL random_c%0d got=%h exp=%h", cyc, obs_a(), exp);
         else passes++;
         if (owner == 0) begin
            if (dbus_req) begin
               owner = 2;
               held = '0;
               held.req = 1; held.we = dbus_we; held.be = dbus_be;
               held.addr = dbus_addr; held.wdata = dbus_wdata;
            end else if (ibus_req) begin
               owner = 1;
               held = '0;
               held.req = 1; held.be = 4'hf; held.addr = ibus_addr;
            end
            gcnt = 0;
         end else if (fin) begin
            owner = 0;
         end else begin
            gcnt++;
         end
      end
      @(negedge clk);
      idle_inputs();
      // Let any transaction still open finish by timeout before the bench ends.
      repeat (6) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_conflict_fixed();
      test_write();
      test_timeout();
      test_reset_mid();
      test_round_robin();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
